// File: rtl/io_core_multi_pkg.sv
// Shared constants, helpers and types for the multi-probe I/O core.
package io_core_multi_pkg;

    // CTRL register bit positions
    localparam int CTRL_CONT = 0;
    localparam int CTRL_SNAP = 1;
    localparam int CTRL_PER  = 2;

    // Register offsets from the base address
    localparam int CTRL_OFS   = 0;
    localparam int PERIOD_OFS = 1;
    localparam int COUNT_OFS  = 2;
    localparam int PROBE_OFS  = 3;

    // Number of 16-bit bus words needed to hold a probe of the given width
    function automatic int words(input int width);
        return (width + 15) / 16;
    endfunction

    // Periodic capture timer states
    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/io_core_multi_if.sv
// Bridge bus between bridge_rx, the probe core and bridge_tx.
// The *_i group is the incoming request, the *_o group the registered
// pass-through / read response.
interface io_core_multi_if;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    modport slave (
        input  addr_i, data_i, rw_i, valid_i,
        output addr_o, data_o, rw_o, valid_o
    );

    modport master (
        output addr_i, data_i, rw_i, valid_i,
        input  addr_o, data_o, rw_o, valid_o
    );
endinterface

// File: rtl/io_core_capture_timer.sv
// Periodic capture timer: counts PERIOD cycles and raises tick when the
// count reaches zero. A reload restarts the count from the new period.
module io_core_capture_timer
    import io_core_multi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        per_en,
    input  logic [15:0] period,
    input  logic        reload,
    output logic        tick
);

    tmr_state_e  state_r;
    tmr_state_e  state_next_s;
    logic [15:0] timer_r;
    logic [15:0] timer_next_s;
    logic        active_s;

    assign active_s = per_en && (period != 16'h0000);

    // State and down-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TMR_IDLE;
            timer_r <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
        end
    end

    // Next-state, counter update and tick decode
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        tick         = 1'b0;
        case (state_r)
            TMR_IDLE: begin
                if (active_s) begin
                    state_next_s = TMR_RUN;
                    timer_next_s = period - 16'd1;
                end else begin
                    timer_next_s = 16'h0000;
                end
            end
            TMR_RUN: begin
                if (!active_s) begin
                    state_next_s = TMR_IDLE;
                    timer_next_s = 16'h0000;
                end else begin
                    tick = (timer_r == 16'h0000);
                    if (reload || (timer_r == 16'h0000)) begin
                        timer_next_s = period - 16'd1;
                    end else begin
                        timer_next_s = timer_r - 16'd1;
                    end
                end
            end
            default: begin
                state_next_s = TMR_IDLE;
                timer_next_s = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/io_core_multi.sv
// Multi-probe I/O core: N_IN input probes and N_OUT double-buffered output
// probes mapped onto the 16-bit bridge bus, with continuous, snapshot and
// periodic capture. Bus traffic passes through with one cycle of latency.
module io_core_multi
    import io_core_multi_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          N_IN      = 3,
    parameter int          IN_WIDTH  = 32,
    parameter int          N_OUT     = 1,
    parameter int          OUT_WIDTH = 16,
    parameter logic [63:0] OUT_RESET = 64'h0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_IN*IN_WIDTH-1:0]                      in_probe,
    output logic [((N_OUT > 0) ? N_OUT : 1)*OUT_WIDTH-1:0] out_probe,
    io_core_multi_if.slave                                bus,
    output logic                                          capture_o
);

    localparam int WI     = words(IN_WIDTH);
    localparam int WO     = words(OUT_WIDTH);
    localparam int NO     = (N_OUT > 0) ? N_OUT : 1;
    localparam int SH_OFS = PROBE_OFS + N_IN * WI;
    localparam int TOTAL  = SH_OFS + N_OUT * WO;
    localparam logic [OUT_WIDTH-1:0] OUT_RST = OUT_RESET[OUT_WIDTH-1:0];

    // Register state
    logic                 cont_r;
    logic                 per_r;
    logic                 pending_r;
    logic [15:0]          period_r;
    logic [15:0]          count_r;
    logic                 reload_r;
    logic                 capture_r;
    logic [IN_WIDTH-1:0]  in_buf_r   [N_IN];
    logic [OUT_WIDTH-1:0] shadow_r   [NO];
    logic [OUT_WIDTH-1:0] out_r      [NO];

    // Decode and datapath
    logic [15:0]          offset_s;
    logic                 in_range_s;
    logic                 rd_s;
    logic                 wr_s;
    logic                 ctrl_wr_s;
    logic                 period_wr_s;
    logic                 snap_wr_s;
    logic                 tick_s;
    logic                 capture_s;
    logic [15:0]          rd_data_s;
    logic [15:0]          rd_word_s      [TOTAL];
    logic [WI*16-1:0]     in_pad_s       [N_IN];
    logic [WO*16-1:0]     shadow_pad_s   [NO];
    logic [OUT_WIDTH-1:0] shadow_next_s  [NO];

    // Addresses below the base wrap to large offsets and fall out of range
    assign offset_s    = bus.addr_i - BASE_ADDR;
    assign in_range_s  = bus.valid_i && (offset_s < 16'(TOTAL));
    assign rd_s        = in_range_s && !bus.rw_i;
    assign wr_s        = in_range_s && bus.rw_i;
    assign ctrl_wr_s   = wr_s && (offset_s == 16'(CTRL_OFS));
    assign period_wr_s = wr_s && (offset_s == 16'(PERIOD_OFS));
    assign snap_wr_s   = ctrl_wr_s && bus.data_i[CTRL_SNAP];
    assign capture_s   = cont_r || pending_r || tick_s;

    io_core_capture_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .per_en (per_r),
        .period (period_r),
        .reload (reload_r),
        .tick   (tick_s)
    );

    // Read word table: control words first, then input and shadow probe words
    assign rd_word_s[CTRL_OFS]   = {13'h0000, per_r, pending_r, cont_r};
    assign rd_word_s[PERIOD_OFS] = period_r;
    assign rd_word_s[COUNT_OFS]  = count_r;

    for (genvar gk = 0; gk < N_IN; gk++) begin : g_in
        assign in_pad_s[gk] = (WI*16)'(in_buf_r[gk]);
        for (genvar gw = 0; gw < WI; gw++) begin : g_in_word
            assign rd_word_s[PROBE_OFS + gk*WI + gw] = in_pad_s[gk][gw*16 +: 16];
        end
    end

    for (genvar gp = 0; gp < N_OUT; gp++) begin : g_sh
        for (genvar gw = 0; gw < WO; gw++) begin : g_sh_word
            assign rd_word_s[SH_OFS + gp*WO + gw] = shadow_pad_s[gp][gw*16 +: 16];
        end
    end

    for (genvar gp = 0; gp < NO; gp++) begin : g_out
        assign out_probe[gp*OUT_WIDTH +: OUT_WIDTH] = out_r[gp];
    end

    assign capture_o = capture_r;

    // Read multiplexer over the word table
    always_comb begin
        rd_data_s = 16'h0000;
        for (int i = 0; i < TOTAL; i++) begin
            rd_data_s = (offset_s == 16'(i)) ? rd_word_s[i] : rd_data_s;
        end
    end

    // Shadow write merge; bits beyond OUT_WIDTH in the top word are dropped
    always_comb begin
        for (int p = 0; p < NO; p++) begin
            shadow_pad_s[p] = (WO*16)'(shadow_r[p]);
        end
        for (int p = 0; p < N_OUT; p++) begin
            for (int w = 0; w < WO; w++) begin
                shadow_pad_s[p][w*16 +: 16] =
                    (wr_s && (offset_s == 16'(SH_OFS + p*WO + w))) ?
                    bus.data_i : shadow_pad_s[p][w*16 +: 16];
            end
        end
        for (int p = 0; p < NO; p++) begin
            shadow_next_s[p] = shadow_pad_s[p][OUT_WIDTH-1:0];
        end
    end

    // Bus pass-through with read data substitution
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.addr_o  <= 16'h0000;
            bus.data_o  <= 16'h0000;
            bus.rw_o    <= 1'b0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.addr_o  <= bus.addr_i;
            bus.data_o  <= rd_s ? rd_data_s : bus.data_i;
            bus.rw_o    <= bus.rw_i;
            bus.valid_o <= bus.valid_i;
        end
    end

    // Control registers, capture buffers and capture pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cont_r    <= 1'b0;
            per_r     <= 1'b0;
            pending_r <= 1'b0;
            period_r  <= 16'h0000;
            count_r   <= 16'h0000;
            reload_r  <= 1'b0;
            capture_r <= 1'b0;
            for (int k = 0; k < N_IN; k++) in_buf_r[k] <= '0;
            for (int p = 0; p < NO; p++) begin
                shadow_r[p] <= OUT_RST;
                out_r[p]    <= OUT_RST;
            end
        end else begin
            if (ctrl_wr_s) begin
                cont_r <= bus.data_i[CTRL_CONT];
                per_r  <= bus.data_i[CTRL_PER];
            end
            if (period_wr_s) begin
                period_r <= bus.data_i;
            end
            // A pending snapshot always captures this cycle, so a SNAP write
            // arriving now merges into it instead of queueing a second one.
            if (snap_wr_s) begin
                pending_r <= !pending_r;
            end else if (capture_s) begin
                pending_r <= 1'b0;
            end
            reload_r  <= period_wr_s || (ctrl_wr_s && bus.data_i[CTRL_PER]);
            capture_r <= capture_s;
            if (capture_s) begin
                count_r <= count_r + 16'd1;
                for (int k = 0; k < N_IN; k++) begin
                    in_buf_r[k] <= in_probe[k*IN_WIDTH +: IN_WIDTH];
                end
                for (int p = 0; p < NO; p++) begin
                    out_r[p] <= shadow_r[p];
                end
            end
            for (int p = 0; p < NO; p++) begin
                shadow_r[p] <= shadow_next_s[p];
            end
        end
    end

endmodule

// File: tb/tb_io_core_multi.sv
// Directed, table-driven bench for io_core_multi.
module tb_io_core_multi;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk;
    logic        rst;
    logic [95:0] in_probe;
    logic [15:0] out_probe;
    logic        capture_o;

    int checks;
    int errors;
    int exp_count;
    int pulses;
    int first;

    io_core_multi_if bus_if ();

    io_core_multi #(
        .BASE_ADDR (BASE),
        .N_IN      (3),
        .IN_WIDTH  (32),
        .N_OUT     (1),
        .OUT_WIDTH (16),
        .OUT_RESET (64'hA5A5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_probe  (in_probe),
        .out_probe (out_probe),
        .bus       (bus_if),
        .capture_o (capture_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle starting at a falling edge; returns at the next falling
    // edge, when the response to this request is on the outputs.
    task automatic xfer(input logic [15:0] a, input logic [15:0] d,
                        input logic rw, input logic v);
        bus_if.addr_i  = a;
        bus_if.data_i  = d;
        bus_if.rw_i    = rw;
        bus_if.valid_i = v;
        @(negedge clk);
        bus_if.valid_i = 1'b0;
    endtask

    task automatic rd(input logic [15:0] ofs, input string name, input logic [15:0] exp);
        xfer(BASE + ofs, 16'h0000, 1'b0, 1'b1);
        chk(name, {16'h0, bus_if.data_o}, {16'h0, exp});
    endtask

    task automatic wr(input logic [15:0] ofs, input logic [15:0] d);
        xfer(BASE + ofs, d, 1'b1, 1'b1);
    endtask

    task automatic run_count(input int n, output int np, output int fp);
        np = 0;
        fp = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (capture_o) begin
                np++;
                if (fp < 0) fp = i;
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 0;
        rst       = 1'b1;
        in_probe  = {32'h89AB_CDEF, 32'hDEAD_BEEF, 32'h0123_4567};
        bus_if.addr_i  = 16'h0000;
        bus_if.data_i  = 16'h0000;
        bus_if.rw_i    = 1'b0;
        bus_if.valid_i = 1'b0;

        vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{16'h0001, 16'h0000, 1'b0, 16'h0000};
        vecs[2]  = '{16'h0002, 16'h0000, 1'b0, 16'h0001};
        vecs[3]  = '{16'h0003, 16'h0000, 1'b0, 16'h4567};
        vecs[4]  = '{16'h0004, 16'h0000, 1'b0, 16'h0123};
        vecs[5]  = '{16'h0005, 16'h0000, 1'b0, 16'hBEEF};
        vecs[6]  = '{16'h0006, 16'h0000, 1'b0, 16'hDEAD};
        vecs[7]  = '{16'h0007, 16'h0000, 1'b0, 16'hCDEF};
        vecs[8]  = '{16'h0008, 16'h0000, 1'b0, 16'h89AB};
        vecs[9]  = '{16'h0009, 16'h0000, 1'b0, 16'hA5A5};
        vecs[10] = '{16'h0009, 16'h1234, 1'b1, 16'h1234};
        vecs[11] = '{16'h0009, 16'h0000, 1'b0, 16'h1234};
        vecs[12] = '{16'h0001, 16'hBEEF, 1'b1, 16'hBEEF};
        vecs[13] = '{16'h0001, 16'h0000, 1'b0, 16'hBEEF};
        vecs[14] = '{16'h0001, 16'h0000, 1'b1, 16'h0000};
        vecs[15] = '{16'h0003, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[16] = '{16'h0003, 16'h0000, 1'b0, 16'h4567};
        vecs[17] = '{16'h0000, 16'hFFF8, 1'b1, 16'hFFF8};
        vecs[18] = '{16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[19] = '{16'h0020, 16'h5A5A, 1'b0, 16'h5A5A};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_probe", {16'h0, out_probe}, 32'hA5A5);
        chk("reset_capture", {31'h0, capture_o}, 32'h0);
        chk("reset_valid_o", {31'h0, bus_if.valid_o}, 32'h0);
        rd(16'h0002, "reset_count", 16'h0000);
        rd(16'h0003, "reset_inbuf", 16'h0000);

        // Snapshot: pulse appears two cycles after the CTRL write
        wr(16'h0000, 16'h0002);
        chk("snap_no_early_pulse", {31'h0, capture_o}, 32'h0);
        @(negedge clk);
        chk("snap_pulse", {31'h0, capture_o}, 32'h1);
        chk("snap_out_probe", {16'h0, out_probe}, 32'hA5A5);
        exp_count++;
        run_count(4, pulses, first);
        chk("snap_single_pulse", pulses, 32'h0);

        // Register table after one snapshot
        for (int i = 0; i < 20; i++) begin
            xfer(BASE + vecs[i].addr, vecs[i].data, vecs[i].rw, 1'b1);
            chk($sformatf("vec%0d_data", i), {16'h0, bus_if.data_o}, {16'h0, vecs[i].exp});
            chk($sformatf("vec%0d_addr", i), {16'h0, bus_if.addr_o}, {16'h0, BASE + vecs[i].addr});
            chk($sformatf("vec%0d_valid", i), {31'h0, bus_if.valid_o}, 32'h1);
        end

        // Pass-through of an idle request and of an address below the base
        xfer(BASE + 16'h0003, 16'h1111, 1'b0, 1'b0);
        chk("idle_passthru", {16'h0, bus_if.data_o}, 32'h1111);
        chk("idle_valid_o", {31'h0, bus_if.valid_o}, 32'h0);
        xfer(16'h0005, 16'h2222, 1'b0, 1'b1);
        chk("below_base_passthru", {16'h0, bus_if.data_o}, 32'h2222);

        // Atomic output update: shadow holds 1234, out_probe waits for capture
        chk("atomic_hold", {16'h0, out_probe}, 32'hA5A5);
        wr(16'h0000, 16'h0002);
        chk("atomic_before", {16'h0, out_probe}, 32'hA5A5);
        @(negedge clk);
        chk("atomic_after", {16'h0, out_probe}, 32'h1234);
        exp_count++;

        // Buffer read in the capture cycle returns the old value
        in_probe[31:0] = 32'hCAFE_F00D;
        wr(16'h0000, 16'h0002);
        rd(16'h0003, "rd_during_capture", 16'h4567);
        chk("rd_during_capture_pulse", {31'h0, capture_o}, 32'h1);
        rd(16'h0003, "rd_after_capture", 16'hF00D);
        exp_count++;

        // Shadow write in the capture cycle
        wr(16'h0000, 16'h0002);
        wr(16'h0009, 16'h7777);
        chk("shadow_wr_capture_out", {16'h0, out_probe}, 32'h1234);
        rd(16'h0009, "shadow_kept", 16'h7777);
        chk("shadow_not_applied", {16'h0, out_probe}, 32'h1234);
        wr(16'h0000, 16'h0002);
        @(negedge clk);
        chk("shadow_next_capture", {16'h0, out_probe}, 32'h7777);
        exp_count += 2;

        // Back-to-back SNAP writes merge into one capture
        wr(16'h0000, 16'h0002);
        wr(16'h0000, 16'h0002);
        chk("snap_merge_pulse", {31'h0, capture_o}, 32'h1);
        run_count(4, pulses, first);
        chk("snap_merge_no_second", pulses, 32'h0);
        exp_count++;
        rd(16'h0002, "count_after_snaps", 16'(exp_count));

        // Periodic capture with PERIOD=4
        wr(16'h0001, 16'h0004);
        wr(16'h0000, 16'h0004);
        run_count(40, pulses, first);
        chk("per_pulses", pulses, 32'd9);
        chk("per_first", first, 32'd5);
        wr(16'h0000, 16'h0000);
        exp_count += 10;
        run_count(20, pulses, first);
        chk("per_stopped", pulses, 32'h0);
        rd(16'h0002, "count_after_per", 16'(exp_count));

        // Reset during operation drops the in-flight response
        wr(16'h0000, 16'h0001);
        repeat (2) @(negedge clk);
        bus_if.addr_i  = BASE + 16'h0002;
        bus_if.rw_i    = 1'b0;
        bus_if.valid_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus_if.valid_i = 1'b0;
        rst = 1'b0;
        chk("midrst_valid_o", {31'h0, bus_if.valid_o}, 32'h0);
        chk("midrst_capture", {31'h0, capture_o}, 32'h0);
        chk("midrst_out_probe", {16'h0, out_probe}, 32'hA5A5);
        rd(16'h0000, "midrst_ctrl", 16'h0000);
        rd(16'h0002, "midrst_count", 16'h0000);

        // Continuous mode: 1-cycle lag, then COUNT wraps to 1 after 65537 captures
        wr(16'h0000, 16'h0001);
        in_probe[31:0] = 32'h1111_2222;
        @(negedge clk);
        in_probe[31:0] = 32'h3333_4444;
        rd(16'h0003, "cont_lag_lo", 16'h2222);
        rd(16'h0004, "cont_lag_hi", 16'h3333);
        repeat (65533) @(negedge clk);
        wr(16'h0000, 16'h0000);
        rd(16'h0002, "count_wrap", 16'h0001);
        rd(16'h0003, "cont_final_buf", 16'h4444);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
